rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Arbitrates the single-port synchronous instruction ROM (10-bit word address, 32-bit data, one-cycle registered read) between two requesters.
- Port 0 is instruction fetch; port 1 is the secondary reader (constant/debug load).
- Grants at most one read per cycle with valid/ready handshakes and returns each result on the requester's own response port exactly one cycle after acceptance.
- Fixed priority to port 0, with a starvation guard that forces a port 1 grant.

Parameters:
- ADDR_W, 10, ROM word-address width.
- DATA_W, 32, ROM data width.
- MAX_WAIT, 4, consecutive cycles port 1 may be valid-but-ungranted before it is forced to win (legal range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 read request.
- req0_addr  in  ADDR_W  port 0 word address.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 read data valid (single-cycle pulse).
- rsp0_data  out  DATA_W  port 0 read data.
- req1_valid  in  1  port 1 read request.
- req1_addr  in  ADDR_W  port 1 word address.
- req1_ready  out  1  port 1 request accepted this cycle.
- rsp1_valid  out  1  port 1 read data valid (single-cycle pulse).
- rsp1_data  out  DATA_W  port 1 read data.
- rom_addr  out  ADDR_W  address to the ROM (sampled by ROM on clk).
- rom_dout  in  DATA_W  ROM registered read data.

Behaviour:
- Reset (async, rst=1):
  - rsp0_valid=0, rsp1_valid=0, req0_ready=0, req1_ready=0.
  - last_addr=0, so rom_addr=0.
  - FSM=PRI0, wait counter=0, pending response tag cleared.
- Response data: rsp0_data and rsp1_data are both driven directly by rom_dout and are meaningful only while the matching rsp*_valid is high.
- Acceptance: handshake completes when valid&ready at a rising edge. Ready is combinational from the current valid inputs and FSM state; at most one ready is high per cycle.
- FSM:
  - PRI0: if req0_valid, grant port 0; else if req1_valid, grant port 1.
  - PRI1: if req1_valid, grant port 1; else if req0_valid, grant port 0.
  - PRI0 -> PRI1 when the counter reaches MAX_WAIT at an edge.
  - PRI1 -> PRI0 on the edge where port 1 is granted, or where req1_valid is low.
- Wait counter:
  - Increments (saturating at MAX_WAIT) on each edge with req1_valid=1 and port 1 not granted.
  - Clears on a port 1 grant or when req1_valid=0.
- ROM address: rom_addr = granted request's address when a grant exists; otherwise last_addr. last_addr updates on every grant, so the ROM address is held stable while idle.
- Latency:
  - Request accepted at edge k.
  - rsp<p>_valid=1 for exactly the cycle between edges k and k+1, carrying rom_dout for that address.
  - Throughput is one read per cycle; back-to-back grants produce back-to-back responses, interleaved by tag.
- Responses have no backpressure; requesters must consume rsp on the valid cycle.
- Simultaneous requests: only one is granted. The loser keeps valid and address stable until it sees ready (requester obligation).
- Request dropping valid before acceptance is legal and is not counted as a grant.
- Reset mid-operation: any in-flight response is discarded (no rsp pulse after rst deasserts). The first grant is possible in the first cycle with rst=0.

Test Plan:
- Bench ROM model returns 32'hA500_0000 | addr.
- Single port 0: req0 addr=17 for one cycle -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_data=32'hA500_0011; rsp1_valid stays 0.
- Back-to-back port 0: addrs 0,1,2 on consecutive cycles -> rsp0_valid high 3 consecutive cycles with data A500_0000, A500_0001, A500_0002.
- Contention with starvation guard (MAX_WAIT=4):
  - req0 continuously valid (addr=5), req1 valid with addr=831.
  - Port 0 is granted 4 cycles, then req1_ready=1 on cycle 5, and rsp1_data=32'hA500_033F the following cycle.
  - Port 0 is regranted immediately after.
- Port 1 alone, FSM in PRI0: req1 addr=3 -> granted immediately; counter stays 0; rsp1_data=32'hA500_0003.
- Idle hold: a grant at addr=17 followed by 5 idle cycles -> rom_addr remains 17; no rsp pulses.
- Reset mid-flight:
  - rst asserted asynchronously between an accept edge and the response cycle -> rsp0_valid falls to 0 immediately, rom_addr=0.
  - After release, a new req0 addr=2 returns A500_0002 with 1-cycle latency.

Source files
------------

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one single-port synchronous instruction ROM (registered read,
//   one-cycle latency) between two requesters. Port 0 (instruction fetch)
//   has fixed priority; port 1 (constant/debug reader) is forced to win once
//   it has been held off for MAX_WAIT consecutive cycles.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/addr/ready    port 0 request handshake
//   rsp0_valid/data          port 0 response, one cycle after acceptance
//   req1_valid/addr/ready    port 1 request handshake
//   rsp1_valid/data          port 1 response, one cycle after acceptance
//   rom_addr                 address presented to the ROM
//   rom_dout                 ROM registered read data
module rom_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_nxt;
    logic              gnt0;
    logic              gnt1;
    logic              vld_p1;
    logic              tag_p1;
    logic [ADDR_W-1:0] last_addr;

    // Stage p0: arbitration, ROM address select, next-state
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        wait_nxt  = wait_cnt;

        // No grants while reset is held, so ready stays low in reset.
        if (!rst) begin
            if (state == PRI0) begin
                gnt0 = req0_valid;
                gnt1 = req1_valid & ~req0_valid;
            end else begin
                gnt1 = req1_valid;
                gnt0 = req0_valid & ~req1_valid;
            end
        end

        // Counts consecutive cycles port 1 is waiting; saturates at WAIT_MAX.
        if (req1_valid && !gnt1) begin
            wait_nxt = (wait_cnt < WAIT_MAX) ? wait_cnt + 4'd1 : wait_cnt;
        end else begin
            wait_nxt = 4'd0;
        end

        // The switch to PRI1 happens on the very edge the count saturates,
        // so port 1 wins in the following cycle.
        case (state)
            PRI0:    if (wait_nxt == WAIT_MAX) state_nxt = PRI1;
            PRI1:    if (gnt1 || !req1_valid) state_nxt = PRI0;
            default: state_nxt = PRI0;
        endcase
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Idle cycles keep the last granted address on the ROM.
    assign rom_addr = gnt0 ? req0_addr : (gnt1 ? req1_addr : last_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PRI0;
            wait_cnt  <= 4'd0;
            vld_p1    <= 1'b0;
            tag_p1    <= 1'b0;
            last_addr <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            vld_p1   <= gnt0 | gnt1;
            tag_p1   <= gnt1;
            if (gnt0 || gnt1) begin
                last_addr <= rom_addr;
            end
        end
    end

    // Stage p1: ROM data returns, steered to the requester by the tag
    assign rsp0_valid = vld_p1 & ~tag_p1;
    assign rsp1_valid = vld_p1 &  tag_p1;
    assign rsp0_data  = rom_dout;
    assign rsp1_data  = rom_dout;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
//   Bench for rom_arbiter: a behavioural ROM (data = 0xA500_0000 | addr),
//   a reference arbiter model feeding an expected-response queue, and
//   directed scenarios with fixed expected values.
module tb_rom_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic          req0_ready;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_data;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic          req1_ready;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_data;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout = '0;

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romv(input logic [AW-1:0] a);
        return 32'hA500_0000 | {22'd0, a};
    endfunction

    // Registered-read ROM
    always @(posedge clk) rom_dout <= romv(rom_addr);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] d;
    } exp_t;

    exp_t          sbq[$];
    logic          m_pri1 = 1'b0;
    int            m_cnt  = 0;
    logic [AW-1:0] m_last = '0;

    // Reference model, evaluated mid-cycle while inputs are stable.
    task automatic monitor();
        logic          g0;
        logic          g1;
        logic [AW-1:0] ea;
        exp_t          e;
        exp_t          n;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                m_pri1 = 1'b0;
                m_cnt  = 0;
                m_last = '0;
                check("rst_rdy0", 64'(req0_ready), 64'd0);
                check("rst_rdy1", 64'(req1_ready), 64'd0);
                check("rst_rsp0", 64'(rsp0_valid), 64'd0);
                check("rst_rsp1", 64'(rsp1_valid), 64'd0);
                check("rst_addr", 64'(rom_addr), 64'd0);
            end else begin
                if (m_pri1) begin
                    g1 = req1_valid;
                    g0 = req0_valid && !req1_valid;
                end else begin
                    g0 = req0_valid;
                    g1 = req1_valid && !req0_valid;
                end
                ea = g0 ? req0_addr : (g1 ? req1_addr : m_last);
                check("rdy0", 64'(req0_ready), 64'(g0));
                check("rdy1", 64'(req1_ready), 64'(g1));
                check("rom_addr", 64'(rom_addr), 64'(ea));

                if (sbq.size() > 0) e = sbq.pop_front();
                else e = '{v0: 1'b0, v1: 1'b0, d: 32'd0};
                check("rsp0_v", 64'(rsp0_valid), 64'(e.v0));
                check("rsp1_v", 64'(rsp1_valid), 64'(e.v1));
                if (e.v0) check("rsp0_d", 64'(rsp0_data), 64'(e.d));
                if (e.v1) check("rsp1_d", 64'(rsp1_data), 64'(e.d));

                n.v0 = g0;
                n.v1 = g1;
                n.d  = romv(ea);
                sbq.push_back(n);

                if (g0 || g1) m_last = ea;
                if (req1_valid && !g1) begin
                    if (m_cnt < MW) m_cnt = m_cnt + 1;
                end else begin
                    m_cnt = 0;
                end
                if (!m_pri1) begin
                    if (m_cnt == MW) m_pri1 = 1'b1;
                end else if (g1 || !req1_valid) begin
                    m_pri1 = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic acc0;
    logic acc1;

    initial begin
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #2;
        check("init_rsp0", 64'(rsp0_valid), 64'd0);
        check("init_addr", 64'(rom_addr), 64'd0);
        step();
        rst = 1'b0;

        // Single port 0 read
        req0_valid = 1'b1;
        req0_addr  = 10'd17;
        #1 check("s0_rdy", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0;
        #2;
        check("s0_rspv", 64'(rsp0_valid), 64'd1);
        check("s0_rspd", 64'(rsp0_data), 64'h0000_0000_A500_0011);
        check("s0_rsp1", 64'(rsp1_valid), 64'd0);
        step();
        step();

        // Back-to-back port 0
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1;
            req0_addr  = 10'(i);
            if (i > 0) begin
                #1 check("b2b_d", 64'(rsp0_data), 64'(romv(10'(i - 1))));
            end
            step();
        end
        req0_valid = 1'b0;
        #1 check("b2b_last", 64'(rsp0_data), 64'h0000_0000_A500_0002);
        step();
        step();

        // Contention: port 1 forced in after MAX_WAIT cycles
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1;
            req0_addr  = 10'd5;
            req1_valid = (i <= 4);
            req1_addr  = 10'd831;
            #1;
            check("sv_rdy1", 64'(req1_ready), 64'(i == 4));
            check("sv_rdy0", 64'(req0_ready), 64'(i != 4));
            if (i == 5) begin
                check("sv_rsp1v", 64'(rsp1_valid), 64'd1);
                check("sv_rsp1d", 64'(rsp1_data), 64'h0000_0000_A500_033F);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();

        // Port 1 alone while port 0 has priority
        req1_valid = 1'b1;
        req1_addr  = 10'd3;
        #1 check("p1_rdy", 64'(req1_ready), 64'd1);
        step();
        req1_valid = 1'b0;
        #1;
        check("p1_rspv", 64'(rsp1_valid), 64'd1);
        check("p1_rspd", 64'(rsp1_data), 64'h0000_0000_A500_0003);
        step();

        // Idle hold of the ROM address
        req0_valid = 1'b1;
        req0_addr  = 10'd17;
        step();
        req0_valid = 1'b0;
        req0_addr  = 10'd900;
        for (int i = 0; i < 5; i++) begin
            #1 check("idle_addr", 64'(rom_addr), 64'd17);
            step();
        end

        // Reset between accept edge and response cycle
        req0_valid = 1'b1;
        req0_addr  = 10'd9;
        step();
        req0_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rsp0", 64'(rsp0_valid), 64'd0);
        check("mid_addr", 64'(rom_addr), 64'd0);
        step();
        step();
        rst        = 1'b0;
        req0_valid = 1'b1;
        req0_addr  = 10'd2;
        #1 check("post_rdy", 64'(req0_ready), 64'd1);
        step();
        req0_valid = 1'b0;
        #1;
        check("post_rspv", 64'(rsp0_valid), 64'd1);
        check("post_rspd", 64'(rsp0_data), 64'h0000_0000_A500_0002);
        step();

        // Random traffic; a waiting requester holds valid and address
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!req0_valid || acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_addr  = 10'($urandom_range(0, 1023));
            end
            if (!req1_valid || acc1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr  = 10'($urandom_range(0, 1023));
            end
            #3;
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
